bp_resolve_unit: RTL and testbench
==================================

// Module: bp_resolve_unit
// PURPOSE
//  EX-stage counterpart of the IF-stage branch predictor. Carries each fetched instruction's prediction
//  (taken bit + predicted target) through IF/ID and ID/EX, and checks it against the real outcome in EX.
//  Sends the 2-bit training outcome back to the predictor, and sends a registered redirect (flag + address)
//  to ctrl on a mispredict. Squashes the wrong-path instruction that is in EX during the redirect cycle.
// PARAMETERS
//  SQUASH_CYCLES  1   cycles after a redirect in which EX-stage resolutions are ignored (1..3)
// PORTS
//  clk              in   1   core clock
//  rst              in   1   reset, asynchronous, active-low
//  hold_flag_i      in   3   `Hold_Flag_Bus from ctrl; >=`Hold_If bubbles IF/ID, >=`Hold_Id bubbles ID/EX
//  if_isbranch_i    in   1   predictor says taken, for the instruction currently in IF
//  if_pred_addr_i   in   32  predicted target, for the instruction in IF
//  ex_inst_i        in   32  instruction in EX
//  ex_inst_addr_i   in   32  PC of the instruction in EX
//  ex_cond_i        in   1   B-type condition result from EX ALU (1 = condition true)
//  branch_taken_o   out  2   training outcome: 00 none, 01 not taken, 10 taken (registered, 1-cycle pulse)
//  jump_flag_o      out  1   redirect request to ctrl (registered, 1-cycle pulse)
//  jump_addr_o      out  32  redirect target; valid only while jump_flag_o=1, else 0
//  branch_cnt_o     out  32  resolved conditional branches (only with BP_PERF_CNT_EN)
//  mispred_cnt_o    out  32  redirects issued (only with BP_PERF_CNT_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): all pipe entries invalid, state RUN, every output 0.
//  - Pipe entry = {valid, pred_taken, pred_addr[31:0]}; one stage per IF/ID and ID/EX, advances every cycle.
//    IF/ID loads {1, if_isbranch_i, if_pred_addr_i}; a hold (per the thresholds above) loads an invalid entry.
//    ID/EX loads from IF/ID the same way.
//  - Resolution happens only when the EX entry is valid and state==RUN. Target T = ex_inst_addr_i + B-imm
//    (sign-extended, bit0=0); fall-through F = ex_inst_addr_i + 4; all arithmetic modulo 2^32.
//    B-type (`INST_TYPE_B, funct3 BEQ/BNE/BLT/BGE/BLTU/BGEU); actual outcome = ex_cond_i:
//      pred 0, actual 0: no redirect, outcome 01.
//      pred 0, actual 1: redirect to T, outcome 10.
//      pred 1, actual 0: redirect to F, outcome 01.
//      pred 1, actual 1: outcome 10; redirect to T only if pred_addr != T.
//    JAL: never redirects (predicted target already exact), outcome 00.
//    Any other opcode with pred_taken=1: redirect to F, outcome 00. Otherwise: nothing.
//  - All decisions are registered: branch_taken_o, jump_flag_o and jump_addr_o appear exactly 1 cycle after
//    the EX cycle that resolved them, and return to 0 the cycle after that.
//  - FSM: RUN -> SQUASH on any redirect decision; SQUASH lasts SQUASH_CYCLES cycles (down-counter), then RUN.
//    In SQUASH, EX entries generate no outcome and no redirect (wrong path).
//  - Simultaneous hold and resolution: the current EX resolution still counts; holds only affect stage loads.
//  - An async reset during SQUASH or while an output pulse is pending clears everything; nothing is replayed.
// CONFIGURATION
//  BP_PERF_CNT_EN defined: branch_cnt_o +1 on each B-type resolution, mispred_cnt_o +1 on each redirect.
//    Both counters saturate at 32'hFFFF_FFFF and reset to 0.
//  BP_PERF_CNT_EN undefined: no counter flops; both ports tied to 32'h0.
// STRUCTURE
//  - defines.v: existing `Hold_Flag_Bus, `Hold_If, `Hold_Id, `INST_TYPE_B, `INST_JAL, `INST_B* funct3 codes,
//    `JumpEnable, `ZeroWord; new `BrRes_None 2'b00, `BrRes_NotTaken 2'b01, `BrRes_Taken 2'b10.
//  - Sub-module bp_pred_pipe: one 34-bit stage (valid, pred bit, address) with async active-low reset and a
//    bubble-on-hold input; instantiated twice (IF/ID, ID/EX).
//  - Top level: decode, target adder, compare, FSM, output registers, optional counters.
// TESTING
//  1 BEQ @0x100, imm=+0x20, pred 0, cond 1 -> 1 cycle later: jump_flag_o=1, jump_addr_o=0x120, branch_taken_o=10.
//  2 BNE @0x200, pred 1 to 0x1F0, cond 0 -> jump_addr_o=0x204, branch_taken_o=01; next EX entry gives no
//    outcome (SQUASH).
//  3 BLT pred 1, pred_addr=0x300, actual T=0x300, cond 1 -> branch_taken_o=10, jump_flag_o stays 0.
//  4 JAL pred 1, and an ADDI with pred 0 -> no redirect, branch_taken_o=00. An ADDI with pred 1 -> redirect
//    to PC+4.
//  5 hold_flag_i=`Hold_Id for 1 cycle while a predicted branch is in IF -> entry dropped; EX sees invalid,
//    all outputs 0.
//  6 rst asserted mid-SQUASH with jump_flag_o=1 -> outputs 0 at once, no clock edge needed; BP_PERF_CNT_EN
//    build counts 3 branches and 2 redirects over tests 1-3.

Source files
------------

// File: rtl/bp_resolve_unit_pkg.sv
// Shared constants, pipe entry type and B-immediate helper for the branch-prediction resolve unit.
package bp_resolve_unit_pkg;

    localparam int          HOLD_FLAG_W = 3;
    localparam logic [2:0]  HOLD_IF     = 3'b010;
    localparam logic [2:0]  HOLD_ID     = 3'b011;

    localparam logic [6:0]  INST_TYPE_B = 7'b1100011;
    localparam logic [6:0]  INST_JAL    = 7'b1101111;

    localparam logic [2:0]  INST_BEQ    = 3'b000;
    localparam logic [2:0]  INST_BNE    = 3'b001;
    localparam logic [2:0]  INST_BLT    = 3'b100;
    localparam logic [2:0]  INST_BGE    = 3'b101;
    localparam logic [2:0]  INST_BLTU   = 3'b110;
    localparam logic [2:0]  INST_BGEU   = 3'b111;

    localparam logic [1:0]  BR_RES_NONE      = 2'b00;
    localparam logic [1:0]  BR_RES_NOT_TAKEN = 2'b01;
    localparam logic [1:0]  BR_RES_TAKEN     = 2'b10;

    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] addr;
    } pred_entry_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } bp_state_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic is_b_funct3(input logic [2:0] f3);
        return (f3 == INST_BEQ) || (f3 == INST_BNE) || (f3 == INST_BLT) ||
               (f3 == INST_BGE) || (f3 == INST_BLTU) || (f3 == INST_BGEU);
    endfunction

endpackage

// File: rtl/bp_resolve_unit_pipe.sv
// One prediction pipe stage {valid, taken, addr}; a bubble request loads an invalid entry.
module bp_pred_pipe
    import bp_resolve_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  pred_entry_t d,
    output pred_entry_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bp_resolve_unit.sv
// EX-stage branch prediction checker: carries predictions through IF/ID and ID/EX, trains the predictor
// and issues registered redirects. Optional perf counters under `BP_PERF_CNT_EN.
//
// state     | meaning
// ST_RUN    | EX entries are resolved normally
// ST_SQUASH | wrong-path EX entries after a redirect are ignored for SQUASH_CYCLES cycles
module bp_resolve_unit
    import bp_resolve_unit_pkg::*;
#(
    parameter int SQUASH_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HOLD_FLAG_W-1:0] hold_flag_i,
    input  logic                   if_isbranch_i,
    input  logic [31:0]            if_pred_addr_i,
    input  logic [31:0]            ex_inst_i,
    input  logic [31:0]            ex_inst_addr_i,
    input  logic                   ex_cond_i,
    output logic [1:0]             branch_taken_o,
    output logic                   jump_flag_o,
    output logic [31:0]            jump_addr_o,
    output logic [31:0]            branch_cnt_o,
    output logic [31:0]            mispred_cnt_o
);

    pred_entry_t if_entry;
    pred_entry_t ifid_q;
    pred_entry_t idex_q;
    logic        ifid_bubble;
    logic        idex_bubble;

    assign if_entry    = '{valid: 1'b1, taken: if_isbranch_i, addr: if_pred_addr_i};
    assign ifid_bubble = (hold_flag_i >= HOLD_IF);
    assign idex_bubble = (hold_flag_i >= HOLD_ID);

    bp_pred_pipe u_ifid (
        .clk    (clk),
        .rst    (rst),
        .bubble (ifid_bubble),
        .d      (if_entry),
        .q      (ifid_q)
    );

    bp_pred_pipe u_idex (
        .clk    (clk),
        .rst    (rst),
        .bubble (idex_bubble),
        .d      (ifid_q),
        .q      (idex_q)
    );

    bp_state_t   state;
    logic [1:0]  sq_cnt;
    logic [6:0]  opcode;
    logic        is_b;
    logic        is_jal;
    logic        resolve;
    logic [31:0] tgt_addr;
    logic [31:0] fall_addr;
    logic        redir;
    logic [31:0] redir_addr;
    logic [1:0]  br_res;
    logic        b_resolved;

    assign opcode    = ex_inst_i[6:0];
    assign is_b      = (opcode == INST_TYPE_B) && is_b_funct3(ex_inst_i[14:12]);
    assign is_jal    = (opcode == INST_JAL);
    assign resolve   = idex_q.valid && (state == ST_RUN);
    assign tgt_addr  = ex_inst_addr_i + b_imm(ex_inst_i);
    assign fall_addr = ex_inst_addr_i + 32'd4;

    always_comb begin
        redir      = 1'b0;
        redir_addr = ZERO_WORD;
        br_res     = BR_RES_NONE;
        b_resolved = 1'b0;
        if (resolve) begin
            if (is_b) begin
                b_resolved = 1'b1;
                if (ex_cond_i) begin
                    br_res = BR_RES_TAKEN;
                    // A correctly-predicted taken branch can still carry a stale target.
                    if (!idex_q.taken || (idex_q.addr != tgt_addr)) begin
                        redir      = 1'b1;
                        redir_addr = tgt_addr;
                    end
                end else begin
                    br_res = BR_RES_NOT_TAKEN;
                    if (idex_q.taken) begin
                        redir      = 1'b1;
                        redir_addr = fall_addr;
                    end
                end
            end else if (!is_jal && idex_q.taken) begin
                redir      = 1'b1;
                redir_addr = fall_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_RUN;
            sq_cnt         <= 2'd0;
            branch_taken_o <= BR_RES_NONE;
            jump_flag_o    <= 1'b0;
            jump_addr_o    <= ZERO_WORD;
        end else begin
            branch_taken_o <= br_res;
            jump_flag_o    <= redir;
            jump_addr_o    <= redir_addr;
            case (state)
                ST_RUN: begin
                    if (redir) begin
                        state  <= ST_SQUASH;
                        sq_cnt <= 2'(SQUASH_CYCLES - 1);
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt == 2'd0) begin
                        state <= ST_RUN;
                    end else begin
                        sq_cnt <= sq_cnt - 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_o  <= ZERO_WORD;
            mispred_cnt_o <= ZERO_WORD;
        end else begin
            if (b_resolved && (branch_cnt_o != 32'hFFFF_FFFF)) begin
                branch_cnt_o <= branch_cnt_o + 32'd1;
            end
            if (redir && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
            end
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt    = b_resolved;
    assign branch_cnt_o  = ZERO_WORD;
    assign mispred_cnt_o = ZERO_WORD;
`endif

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Directed-vector bench for bp_resolve_unit with hand-computed expectations.
module tb_bp_resolve_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  hold_flag_i = 3'd0;
    logic        if_isbranch_i = 1'b0;
    logic [31:0] if_pred_addr_i = 32'h0;
    logic [31:0] ex_inst_i = NOP;
    logic [31:0] ex_inst_addr_i = 32'h0;
    logic        ex_cond_i = 1'b0;
    logic [1:0]  branch_taken_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    bp_resolve_unit #(.SQUASH_CYCLES(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .hold_flag_i    (hold_flag_i),
        .if_isbranch_i  (if_isbranch_i),
        .if_pred_addr_i (if_pred_addr_i),
        .ex_inst_i      (ex_inst_i),
        .ex_inst_addr_i (ex_inst_addr_i),
        .ex_cond_i      (ex_cond_i),
        .branch_taken_o (branch_taken_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .branch_cnt_o   (branch_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] im);
        return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    // Feeds one prediction into IF, then presents the instruction in EX two cycles later.
    // Returns just after the output registers captured the resolution.
    task automatic run_vec(input logic pred, input logic [31:0] paddr, input logic [31:0] inst,
                           input logic [31:0] pc, input logic cond, input logic [2:0] hold_if,
                           input logic [2:0] hold_ex);
        if_isbranch_i  = pred;
        if_pred_addr_i = paddr;
        hold_flag_i    = hold_if;
        step();
        if_isbranch_i  = 1'b0;
        if_pred_addr_i = 32'h0;
        hold_flag_i    = 3'd0;
        step();
        ex_inst_i      = inst;
        ex_inst_addr_i = pc;
        ex_cond_i      = cond;
        hold_flag_i    = hold_ex;
        step();
        ex_inst_i      = NOP;
        ex_inst_addr_i = 32'h0;
        ex_cond_i      = 1'b0;
        hold_flag_i    = 3'd0;
    endtask

    task automatic chk_out(input string tag, input logic jf, input logic [31:0] ja, input logic [1:0] bt);
        chk({tag, ".jf"}, {31'd0, jump_flag_o}, {31'd0, jf});
        chk({tag, ".ja"}, jump_addr_o, ja);
        chk({tag, ".bt"}, {30'd0, branch_taken_o}, {30'd0, bt});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 2'b00);
        chk("reset.bcnt", branch_cnt_o, 32'h0);
        chk("reset.mcnt", mispred_cnt_o, 32'h0);
        rst = 1'b1;
        step();

        // 1: BEQ @0x100 imm +0x20, pred not taken, actually taken
        run_vec(1'b0, 32'h0, enc_b(3'b000, 13'h0020), 32'h100, 1'b1, 3'd0, 3'd0);
        chk_out("t1", 1'b1, 32'h120, 2'b10);
        step();
        chk_out("t1.clr", 1'b0, 32'h0, 2'b00);
        step();

        // 2: BNE @0x200 pred taken to 0x1F0, actually not taken; next EX entry is squashed
        run_vec(1'b1, 32'h1F0, enc_b(3'b001, 13'h0040), 32'h200, 1'b0, 3'd0, 3'd0);
        chk_out("t2", 1'b1, 32'h204, 2'b01);
        ex_inst_i      = enc_b(3'b000, 13'h0020);
        ex_inst_addr_i = 32'h208;
        ex_cond_i      = 1'b1;
        step();
        ex_inst_i      = NOP;
        ex_inst_addr_i = 32'h0;
        ex_cond_i      = 1'b0;
        chk_out("t2.squash", 1'b0, 32'h0, 2'b00);
        step();

        // 3: BLT @0x2F0 imm +0x10, pred taken to exact target 0x300
        run_vec(1'b1, 32'h300, enc_b(3'b100, 13'h0010), 32'h2F0, 1'b1, 3'd0, 3'd0);
        chk_out("t3", 1'b0, 32'h0, 2'b10);
        step();
`ifdef BP_PERF_CNT_EN
        chk("cnt.branch", branch_cnt_o, 32'd3);
        chk("cnt.mispred", mispred_cnt_o, 32'd2);
`else
        chk("cnt.branch", branch_cnt_o, 32'd0);
        chk("cnt.mispred", mispred_cnt_o, 32'd0);
`endif

        // BGE @0x400 imm -0x40, pred taken to wrong target -> redirect to 0x3C0
        run_vec(1'b1, 32'h3C4, enc_b(3'b101, 13'h1FC0), 32'h400, 1'b1, 3'd0, 3'd0);
        chk_out("bge.badtgt", 1'b1, 32'h3C0, 2'b10);
        step();
        step();

        // BGEU pred not taken, not taken
        run_vec(1'b0, 32'h0, enc_b(3'b111, 13'h0100), 32'h500, 1'b0, 3'd0, 3'd0);
        chk_out("bgeu.nt", 1'b0, 32'h0, 2'b01);
        step();

        // 4: JAL pred taken, ADDI pred 0, ADDI pred 1
        run_vec(1'b1, 32'h708, 32'h0080_006F, 32'h700, 1'b0, 3'd0, 3'd0);
        chk_out("t4.jal", 1'b0, 32'h0, 2'b00);
        run_vec(1'b0, 32'h0, 32'h0010_0093, 32'h800, 1'b0, 3'd0, 3'd0);
        chk_out("t4.addi0", 1'b0, 32'h0, 2'b00);
        run_vec(1'b1, 32'h900, 32'h0010_0093, 32'h600, 1'b0, 3'd0, 3'd0);
        chk_out("t4.addi1", 1'b1, 32'h604, 2'b00);
        step();
        step();

        // wrap-around target: BEQ @0xFFFFFFF0 imm +0x20
        run_vec(1'b0, 32'h0, enc_b(3'b000, 13'h0020), 32'hFFFF_FFF0, 1'b1, 3'd0, 3'd0);
        chk_out("wrap", 1'b1, 32'h10, 2'b10);
        step();
        step();

        // 5: Hold_Id while predicted branch in IF -> entry dropped
        run_vec(1'b1, 32'hA00, enc_b(3'b000, 13'h0020), 32'hA00, 1'b1, 3'd3, 3'd0);
        chk_out("t5.hold", 1'b0, 32'h0, 2'b00);
        step();

        // hold during the EX cycle does not cancel the resolution
        run_vec(1'b0, 32'h0, enc_b(3'b001, 13'h0008), 32'hB00, 1'b1, 3'd0, 3'd3);
        chk_out("hold.ex", 1'b1, 32'hB08, 2'b10);
        step();
        step();

        // 6: async reset while a redirect pulse is showing and FSM is in SQUASH
        run_vec(1'b0, 32'h0, enc_b(3'b000, 13'h0020), 32'h100, 1'b1, 3'd0, 3'd0);
        chk_out("t6.pre", 1'b1, 32'h120, 2'b10);
        rst = 1'b0;
        #1;
        chk_out("t6.rst", 1'b0, 32'h0, 2'b00);
        chk("t6.bcnt", branch_cnt_o, 32'h0);
        chk("t6.mcnt", mispred_cnt_o, 32'h0);
        step();
        rst = 1'b1;
        step();
        chk_out("t6.after", 1'b0, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
